// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 4-stage pipeline sequencer: RAW stalls, branch flush, stall counter.
// Optional operand forwarding is enabled by defining PIPE_HAZARD_FWD_EN.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              DOF_VALID,
  input  logic [REG_AW-1:0] AA,
  input  logic [REG_AW-1:0] BA,
  input  logic              MA,
  input  logic              MB,
  input  logic              RW,
  input  logic [REG_AW-1:0] DA,
  input  logic [1:0]        MD,
  input  logic [1:0]        BS,
  input  logic              PS,
  input  logic              Z_EX,
  output logic              STALL,
  output logic              BUBBLE,
  output logic              FLUSH,
  output logic [1:0]        PC_SEL,
  output logic [1:0]        FWD_A,
  output logic [1:0]        FWD_B,
  output logic [CNT_W-1:0]  STALL_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_FLUSH} state_t;

  state_t            state_q;
  logic              ex_rw_q;
  logic [REG_AW-1:0] ex_da_q;
  logic [1:0]        ex_md_q;
  logic [1:0]        ex_bs_q;
  logic              ex_ps_q;
  logic              wb_rw_q;
  logic [REG_AW-1:0] wb_da_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic active;
  logic use_a, use_b;
  logic a_ex, a_wb, b_ex, b_wb;
  logic taken;
  logic hazard;
  logic stall_c, flush_c;
  logic load_ex;
  logic [1:0] fwd_a_c, fwd_b_c;

  assign active = (state_q != S_IDLE);

  // R0 and non-register operands never create a dependence
  assign use_a = !MA && (AA != '0);
  assign use_b = !MB && (BA != '0);
  assign a_ex  = use_a && ex_rw_q && (ex_da_q == AA);
  assign a_wb  = use_a && wb_rw_q && (wb_da_q == AA);
  assign b_ex  = use_b && ex_rw_q && (ex_da_q == BA);
  assign b_wb  = use_b && wb_rw_q && (wb_da_q == BA);

  always_comb begin
    taken = 1'b0;
    case (ex_bs_q)
      2'b01:   taken = Z_EX ^ ex_ps_q;
      2'b10:   taken = 1'b1;
      2'b11:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

`ifdef PIPE_HAZARD_FWD_EN
  assign hazard  = DOF_VALID && (ex_md_q == 2'b01) && (a_ex || b_ex);
  assign fwd_a_c = a_ex ? 2'b01 : (a_wb ? 2'b10 : 2'b00);
  assign fwd_b_c = b_ex ? 2'b01 : (b_wb ? 2'b10 : 2'b00);
`else
  logic unused_md;
  assign unused_md = ^ex_md_q;
  assign hazard    = DOF_VALID && (a_ex || a_wb || b_ex || b_wb);
  assign fwd_a_c   = 2'b00;
  assign fwd_b_c   = 2'b00;
`endif

  // A taken branch squashes the hazarding instruction, so it wins
  assign flush_c = active && taken;
  assign stall_c = active && hazard && !taken;
  assign load_ex = active && !stall_c && !flush_c && DOF_VALID;
  assign cnt_d   = (stall_c && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  assign STALL     = stall_c;
  assign BUBBLE    = stall_c;
  assign FLUSH     = flush_c;
  assign PC_SEL    = flush_c ? ex_bs_q : 2'b00;
  assign FWD_A     = active ? fwd_a_c : 2'b00;
  assign FWD_B     = active ? fwd_b_c : 2'b00;
  assign STALL_CNT = cnt_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      ex_rw_q <= 1'b0;
      ex_da_q <= '0;
      ex_md_q <= 2'b00;
      ex_bs_q <= 2'b00;
      ex_ps_q <= 1'b0;
      wb_rw_q <= 1'b0;
      wb_da_q <= '0;
      cnt_q   <= '0;
    end else begin
      wb_rw_q <= ex_rw_q;
      wb_da_q <= ex_da_q;
      cnt_q   <= cnt_d;
      if (load_ex) begin
        ex_rw_q <= RW;
        ex_da_q <= DA;
        ex_md_q <= MD;
        ex_bs_q <= BS;
        ex_ps_q <= PS;
      end else begin
        ex_rw_q <= 1'b0;
        ex_da_q <= '0;
        ex_md_q <= 2'b00;
        ex_bs_q <= 2'b00;
        ex_ps_q <= 1'b0;
      end
      if (!active)      state_q <= S_RUN;
      else if (flush_c) state_q <= S_FLUSH;
      else if (stall_c) state_q <= S_STALL;
      else              state_q <= S_RUN;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed bench for pipe_hazard_ctrl against a slot model.
module tb_pipe_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          DOF_VALID;
  logic [AW-1:0] AA, BA, DA;
  logic          MA, MB, RW, PS, Z_EX;
  logic [1:0]    MD, BS;
  logic          STALL, BUBBLE, FLUSH;
  logic [1:0]    PC_SEL, FWD_A, FWD_B;
  logic [CW-1:0] STALL_CNT;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DOF_VALID(DOF_VALID),
    .AA(AA), .BA(BA), .MA(MA), .MB(MB), .RW(RW), .DA(DA), .MD(MD),
    .BS(BS), .PS(PS), .Z_EX(Z_EX),
    .STALL(STALL), .BUBBLE(BUBBLE), .FLUSH(FLUSH), .PC_SEL(PC_SEL),
    .FWD_A(FWD_A), .FWD_B(FWD_B), .STALL_CNT(STALL_CNT)
  );

  typedef struct {
    bit rw;
    int da;
    int md;
    int bs;
    bit ps;
  } slot_t;

  slot_t m_ex, m_wb;
  bit    m_idle;
  int    m_cnt;
  bit    last_stall, last_flush;
  int    n_pass = 0;
  int    n_total = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic bit writes(input slot_t s, input int r);
    return s.rw && (s.da == r);
  endfunction

  function automatic slot_t nop_slot();
    slot_t s;
    s.rw = 0; s.da = 0; s.md = 0; s.bs = 0; s.ps = 0;
    return s;
  endfunction

  task automatic model_reset();
    m_ex = nop_slot();
    m_wb = nop_slot();
    m_idle = 1;
    m_cnt = 0;
    last_stall = 0;
    last_flush = 0;
  endtask

  task automatic set_ins(input bit v, input int aa, input bit ma, input int ba, input bit mb,
                         input bit rw, input int da, input int md, input int bs, input bit ps,
                         input bit z);
    DOF_VALID = v; AA = AW'(aa); MA = ma; BA = AW'(ba); MB = mb;
    RW = rw; DA = AW'(da); MD = 2'(md); BS = 2'(bs); PS = ps; Z_EX = z;
  endtask

  task automatic set_nop(input bit z);
    set_ins(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, z);
  endtask

  // Compare this cycle's outputs with the model, then advance the model one clock
  task automatic run_cycle();
    int  a_src, b_src, fa, fb, e_pc;
    bit  ua, ub, ea, wa, eb, wbb, tk, hz, e_stall, e_flush;
    slot_t nx;
    #1;
    a_src = int'(AA);
    b_src = int'(BA);
    ua  = !MA && (a_src != 0);
    ub  = !MB && (b_src != 0);
    ea  = ua && writes(m_ex, a_src);
    wa  = ua && writes(m_wb, a_src);
    eb  = ub && writes(m_ex, b_src);
    wbb = ub && writes(m_wb, b_src);
    tk  = (m_ex.bs == 1 && (Z_EX != m_ex.ps)) || m_ex.bs >= 2;
`ifdef PIPE_HAZARD_FWD_EN
    hz = DOF_VALID && (m_ex.md == 1) && (ea || eb);
    fa = ea ? 1 : (wa ? 2 : 0);
    fb = eb ? 1 : (wbb ? 2 : 0);
`else
    hz = DOF_VALID && (ea || wa || eb || wbb);
    fa = 0;
    fb = 0;
`endif
    e_flush = !m_idle && tk;
    e_stall = !m_idle && hz && !tk;
    e_pc    = e_flush ? m_ex.bs : 0;
    if (m_idle) begin
      fa = 0;
      fb = 0;
    end
    chk("stall",     int'(STALL),     int'(e_stall));
    chk("bubble",    int'(BUBBLE),    int'(e_stall));
    chk("flush",     int'(FLUSH),     int'(e_flush));
    chk("pc_sel",    int'(PC_SEL),    e_pc);
    chk("fwd_a",     int'(FWD_A),     fa);
    chk("fwd_b",     int'(FWD_B),     fb);
    chk("stall_cnt", int'(STALL_CNT), m_cnt);
    m_wb = m_ex;
    if (m_idle || e_stall || e_flush || !DOF_VALID) nx = nop_slot();
    else begin
      nx.rw = RW; nx.da = int'(DA); nx.md = int'(MD); nx.bs = int'(BS); nx.ps = PS;
    end
    m_ex = nx;
    if (e_stall && m_cnt < CNT_MAX) m_cnt++;
    m_idle = 0;
    last_stall = e_stall;
    last_flush = e_flush;
    @(negedge CLK);
  endtask

  // Issue the held reader until it stops stalling; returns how many stall cycles it saw
  task automatic hold_reader(output int st);
    st = 0;
    for (int k = 0; k < 6; k++) begin
      run_cycle();
      if (last_stall) st++;
      else break;
    end
  endtask

  task automatic dep(input string tag, input int wda, input int wmd, input int raa, input bit rma,
                     input int rba, input bit rmb, input int exp_st);
    int st;
    set_ins(1, 0, 1, 0, 1, 1, wda, wmd, 0, 0, 0);
    run_cycle();
    set_ins(1, raa, rma, rba, rmb, 0, 0, 0, 0, 0, 0);
    hold_reader(st);
    chk(tag, st, exp_st);
    set_nop(0);
    run_cycle();
    run_cycle();
  endtask

  initial begin
    int st;
    int c0;
    RESET_N = 0;
    set_nop(0);
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_stall", int'(STALL), 0);
    chk("rst_flush", int'(FLUSH), 0);
    chk("rst_cnt",   int'(STALL_CNT), 0);
    @(negedge CLK);
    RESET_N = 1;
    run_cycle();
    for (int i = 0; i < 4; i++) run_cycle();

`ifdef PIPE_HAZARD_FWD_EN
    dep("ex_haz_stalls", 3, 0, 3, 0, 0, 1, 0);
    chk("ex_haz_cnt", int'(STALL_CNT), 0);
    dep("load_use_stalls", 5, 1, 0, 1, 5, 0, 1);
`else
    dep("ex_haz_stalls", 3, 0, 3, 0, 0, 1, 2);
    chk("ex_haz_cnt", int'(STALL_CNT), 2);
    dep("load_use_stalls", 5, 1, 0, 1, 5, 0, 2);
`endif
    dep("r0_stalls", 0, 0, 0, 0, 0, 1, 0);
    dep("ma_stalls", 0, 0, 0, 1, 0, 1, 0);
    dep("ma_reg_stalls", 3, 0, 3, 1, 0, 1, 0);

    // Taken branch whose EX destination is read by DOF
    c0 = int'(STALL_CNT);
    set_ins(1, 0, 1, 0, 1, 1, 4, 0, 1, 0, 0);
    run_cycle();
    set_ins(1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    run_cycle();
    chk("br_taken_flush", int'(last_flush), 1);
    chk("br_taken_cnt", int'(STALL_CNT), c0);
    set_nop(0);
    run_cycle();
    run_cycle();
    // Same branch not taken: plain hazard
    set_ins(1, 0, 1, 0, 1, 1, 4, 0, 1, 0, 0);
    run_cycle();
    set_ins(1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    hold_reader(st);
`ifdef PIPE_HAZARD_FWD_EN
    chk("br_not_taken_stalls", st, 0);
`else
    chk("br_not_taken_stalls", st, 2);
`endif
    set_nop(0);
    run_cycle();

    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        if (last_flush) set_nop($urandom_range(0, 1) == 1);
        else set_ins($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end else Z_EX = ($urandom_range(0, 1) == 1);
      run_cycle();
    end
    set_nop(0);
    run_cycle();
    run_cycle();

    // Reset arriving in the middle of a stall
    set_ins(1, 0, 1, 0, 1, 1, 3, 1, 0, 0, 0);
    run_cycle();
    set_ins(1, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    #2;
    RESET_N = 0;
    #1;
    chk("async_rst_stall",  int'(STALL), 0);
    chk("async_rst_bubble", int'(BUBBLE), 0);
    chk("async_rst_flush",  int'(FLUSH), 0);
    chk("async_rst_pcsel",  int'(PC_SEL), 0);
    chk("async_rst_fwd",    int'({FWD_A, FWD_B}), 0);
    chk("async_rst_cnt",    int'(STALL_CNT), 0);
    @(negedge CLK);
    RESET_N = 1;
    model_reset();
    run_cycle();
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      chk("post_rst_no_stall", int'(last_stall), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
